design_1: RTL and testbench

//   Parameterised N-bit binary<->Gray code converter with a registered output stage.

---
 rtl/design_1.sv | 113 +++++++++++
 tb/tb_design_1.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/design_1.sv
// ---------------------------------------------------------------------------
// design_1 : N-bit binary <-> Gray code converter with a registered output.
//
// Each accepted sample is converted in the direction selected by mode and
// presented on out exactly one cycle later, qualified by out_valid. When
// in_valid is low, out keeps its last value and out_valid drops.
//
// Parameters
//   N           data width in bits (N >= 1)
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   in          input word (binary when mode=0, Gray when mode=1)
//   mode        0 = binary->Gray, 1 = Gray->binary
//   in_valid    qualifies in/mode in the current cycle
//   out         converted word (registered)
//   out_valid   high one cycle after an accepted sample
//   out_parity  XOR of all out bits (only when DESIGN_1_PARITY_EN is defined)
//
// Build option
//   DESIGN_1_PARITY_EN : adds the registered out_parity output.
// ---------------------------------------------------------------------------
module design_1 #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] in,
    input  logic         mode,
    input  logic         in_valid,
    output logic [N-1:0] out,
    output logic         out_valid
`ifdef DESIGN_1_PARITY_EN
    ,
    output logic         out_parity
`endif
);

    // Binary to Gray: each bit is the XOR of itself and its upper neighbour.
    function automatic logic [N-1:0] bin2gray(input logic [N-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Gray to binary: running XOR starting from the MSB.
    function automatic logic [N-1:0] gray2bin(input logic [N-1:0] g);
        logic [N-1:0] b;
        b = g;
        for (int i = N - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

`ifdef DESIGN_1_PARITY_EN
    // Even-parity helper: XOR reduction of the word.
    function automatic logic parity_of(input logic [N-1:0] x);
        return ^x;
    endfunction
`endif

    logic [N-1:0] conv_s;
    logic [N-1:0] out_r;
    logic         out_valid_r;

    // Select the conversion direction for the current sample.
    always_comb begin
        conv_s = {N{1'b0}};
        if (mode == 1'b1) begin
            conv_s = gray2bin(in);
        end else begin
            conv_s = bin2gray(in);
        end
    end

    // Output register: load on accepted samples, hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_r       <= {N{1'b0}};
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= in_valid;
            if (in_valid) begin
                out_r <= conv_s;
            end else begin
                out_r <= out_r;
            end
        end
    end

    assign out       = out_r;
    assign out_valid = out_valid_r;

`ifdef DESIGN_1_PARITY_EN
    logic out_parity_r;

    // Parity register tracks out_r so both change on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_parity_r <= 1'b0;
        end else begin
            if (in_valid) begin
                out_parity_r <= parity_of(conv_s);
            end else begin
                out_parity_r <= out_parity_r;
            end
        end
    end

    assign out_parity = out_parity_r;
`endif

endmodule

// File: tb/tb_design_1.sv
// ---------------------------------------------------------------------------
// tb_design_1 : directed self-checking bench for design_1 (N=4).
// ---------------------------------------------------------------------------
module tb_design_1;

    localparam int N = 4;

    logic         clk;
    logic         clk_en;
    logic         rst;
    logic [N-1:0] in;
    logic         mode;
    logic         in_valid;
    logic [N-1:0] out;
    logic         out_valid;
`ifdef DESIGN_1_PARITY_EN
    logic         out_parity;
`endif

    int checks;
    int errors;

    // Gray code of 0..15, written out by hand.
    logic [3:0] gray_tab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                  4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

    design_1 #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in        (in),
        .mode      (mode),
        .in_valid  (in_valid),
        .out       (out),
        .out_valid (out_valid)
`ifdef DESIGN_1_PARITY_EN
        ,
        .out_parity(out_parity)
`endif
    );

    // Gated clock so the first reset can be applied with the clock idle.
    initial clk = 1'b0;
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic chk_out(input string tag, input logic [N-1:0] exp_out, input logic exp_valid);
        checks++;
        assert (out === exp_out) else begin
            errors++;
            $error("FAIL %s out observed=%h expected=%h", tag, out, exp_out);
        end
        checks++;
        assert (out_valid === exp_valid) else begin
            errors++;
            $error("FAIL %s out_valid observed=%b expected=%b", tag, out_valid, exp_valid);
        end
`ifdef DESIGN_1_PARITY_EN
        if (exp_valid) begin
            checks++;
            assert (out_parity === ^exp_out) else begin
                errors++;
                $error("FAIL %s out_parity observed=%b expected=%b", tag, out_parity, ^exp_out);
            end
        end
`endif
    endtask

    // Apply one cycle of stimulus, then sample just after the edge.
    task automatic step(input logic v, input logic m, input logic [N-1:0] x);
        in_valid = v;
        mode     = m;
        in       = x;
        @(posedge clk);
        #1;
    endtask

    logic [N-1:0] g;

    initial begin
        checks   = 0;
        errors   = 0;
        clk_en   = 1'b0;
        rst      = 1'b0;
        in       = 4'h0;
        mode     = 1'b0;
        in_valid = 1'b0;

        // 1. reset pulse with clock idle
        #2 rst = 1'b1;
        #1 chk_out("reset_async", 4'h0, 1'b0);
        #2 rst = 1'b0;
        #1 chk_out("reset_release", 4'h0, 1'b0);
        clk_en = 1'b1;

        // 2. binary -> Gray, back-to-back
        step(1'b1, 1'b0, 4'h0); chk_out("b2g_0", 4'h0, 1'b1);
        step(1'b1, 1'b0, 4'h1); chk_out("b2g_1", 4'h1, 1'b1);
        step(1'b1, 1'b0, 4'h2); chk_out("b2g_2", 4'h3, 1'b1);
        step(1'b1, 1'b0, 4'h3); chk_out("b2g_3", 4'h2, 1'b1);

        // 3. Gray -> binary
        step(1'b1, 1'b1, 4'h2); chk_out("g2b_2", 4'h3, 1'b1);
        step(1'b1, 1'b1, 4'h6); chk_out("g2b_6", 4'h4, 1'b1);

        // 4. all-ones boundary, alternating mode
        step(1'b1, 1'b0, 4'hF); chk_out("b2g_F", 4'h8, 1'b1);
        step(1'b1, 1'b1, 4'hF); chk_out("g2b_F", 4'hA, 1'b1);

        // idle holds out, drops out_valid
        step(1'b0, 1'b0, 4'h5); chk_out("idle_hold", 4'hA, 1'b0);

        // 5. exhaustive round trip with periodic gaps
        for (int x = 0; x < 16; x++) begin
            step(1'b1, 1'b0, 4'(x));
            chk_out($sformatf("rt_fwd_%0d", x), gray_tab[x], 1'b1);
            g = out;
            step(1'b1, 1'b1, g);
            chk_out($sformatf("rt_back_%0d", x), 4'(x), 1'b1);
            if ((x % 4) == 3) begin
                step(1'b0, 1'b1, 4'hC);
                chk_out($sformatf("rt_gap_%0d", x), 4'(x), 1'b0);
            end
        end

        // 6. reset mid-stream with in_valid held high
        step(1'b1, 1'b0, 4'h3); chk_out("pre_rst", 4'h2, 1'b1);
        in_valid = 1'b1;
        mode     = 1'b0;
        in       = 4'h5;
        #2 rst = 1'b1;
        #1 chk_out("rst_mid_async", 4'h0, 1'b0);
        @(posedge clk);
        #1 chk_out("rst_mid_held", 4'h0, 1'b0);
        #3 rst = 1'b0;
        @(posedge clk);
        #1 chk_out("post_rst_first", 4'h7, 1'b1);
        step(1'b0, 1'b0, 4'h0); chk_out("post_rst_idle", 4'h7, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
